// File: rtl/fft_frame_pkg.sv
// fft_frame_pkg: shared types and helpers for the FFT frame gearbox.
//   in_state_e  - input-side FSM states (FILL collects words, HOLD offers the frame)
//   out_state_e - output-side FSM states (IDLE waits for a result, DRAIN streams it)
//   clamp_log2  - limits a requested length exponent to 1..log2n
//   bitrev      - reverses the low l bits of an index (l <= MAX_LOG2)
package fft_frame_pkg;

  localparam int unsigned MAX_LOG2 = 16;

  typedef enum logic {
    IN_FILL = 1'b0,
    IN_HOLD = 1'b1
  } in_state_e;

  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_DRAIN = 1'b1
  } out_state_e;

  // Frames are never shorter than two words nor longer than the buffer.
  function automatic int unsigned clamp_log2(input int unsigned cfg,
                                             input int unsigned log2n);
    int unsigned l;
    l = cfg;
    if (l < 1) l = 1;
    if (l > log2n) l = log2n;
    return l;
  endfunction

  // Shift bits out of the LSB of idx into the LSB of the result, l times.
  function automatic logic [MAX_LOG2-1:0] bitrev(input logic [MAX_LOG2-1:0] idx,
                                                 input int unsigned l);
    logic [MAX_LOG2-1:0] src;
    logic [MAX_LOG2-1:0] res;
    src = idx;
    res = '0;
    for (int unsigned i = 0; i < MAX_LOG2; i++) begin
      if (i < l) begin
        res = {res[MAX_LOG2-2:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_frame_drain.sv
// fft_frame_drain: output side of the gearbox. Latches a whole result frame
// from the FFT and streams it out one word per send handshake, in natural
// or bit-reversed index order.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   i_len_log2           - length exponent of the frame being returned
//   i_bitrev             - drain order select, sampled on the result handshake
//   i_par_recv_msg/_val  - parallel result frame from the FFT
//   o_par_recv_rdy       - ready for a result frame (IDLE only)
//   o_send_msg/_val      - serial output word
//   i_send_rdy           - serial output ready
//   o_frames_out         - count of fully drained frames, wraps at 255
module fft_frame_drain
  import fft_frame_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned LOG2N     = $clog2(N_SAMPLES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(LOG2N+1)-1:0]     i_len_log2,
  input  logic                           i_bitrev,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0] i_par_recv_msg,
  input  logic                           i_par_recv_val,
  output logic                           o_par_recv_rdy,
  output logic [BIT_WIDTH-1:0]           o_send_msg,
  output logic                           o_send_val,
  input  logic                           i_send_rdy,
  output logic [7:0]                     o_frames_out
);

  localparam int unsigned LW = $clog2(LOG2N + 1);
  localparam int unsigned CW = LOG2N;

  out_state_e           r_state;
  logic [CW-1:0]        r_out_cnt;
  logic [LW-1:0]        r_len_out;
  logic                 r_bitrev;
  logic [BIT_WIDTH-1:0] r_obuf [N_SAMPLES];
  logic [BIT_WIDTH-1:0] r_send_msg;
  logic                 r_send_val;
  logic                 r_par_recv_rdy;
  logic [7:0]           r_frames_out;

  logic [BIT_WIDTH-1:0] w_slot [N_SAMPLES];
  logic                 w_recv_fire;
  logic                 w_send_fire;
  logic                 w_last;
  logic [CW-1:0]        w_next_cnt;
  logic [CW-1:0]        w_next_idx;

  // Split the flat result bus into per-sample slots.
  for (genvar g = 0; g < N_SAMPLES; g++) begin : g_slot
    assign w_slot[g] = i_par_recv_msg[g*BIT_WIDTH +: BIT_WIDTH];
  end

  assign w_recv_fire = i_par_recv_val & r_par_recv_rdy;
  assign w_send_fire = r_send_val & i_send_rdy;
  assign w_last      = (32'(r_out_cnt) == ((32'd1 << r_len_out) - 32'd1));
  assign w_next_cnt  = r_out_cnt + CW'(1);
  // Index of the word presented after the current one is accepted.
  assign w_next_idx  = r_bitrev ? CW'(bitrev(MAX_LOG2'(w_next_cnt), 32'(r_len_out)))
                                : w_next_cnt;

  // Output FSM; send_msg is preloaded so it always shows obuf[idx(out_cnt)].
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= OUT_IDLE;
      r_out_cnt      <= '0;
      r_len_out      <= '0;
      r_bitrev       <= 1'b0;
      r_send_msg     <= '0;
      r_send_val     <= 1'b0;
      r_par_recv_rdy <= 1'b1;
      r_frames_out   <= '0;
      for (int unsigned i = 0; i < N_SAMPLES; i++) begin
        r_obuf[CW'(i)] <= '0;
      end
    end else begin
      case (r_state)
        OUT_IDLE: begin
          if (w_recv_fire) begin
            for (int unsigned i = 0; i < N_SAMPLES; i++) begin
              r_obuf[CW'(i)] <= w_slot[CW'(i)];
            end
            r_len_out      <= i_len_log2;
            r_bitrev       <= i_bitrev;
            r_out_cnt      <= '0;
            r_send_msg     <= w_slot[0];
            r_send_val     <= 1'b1;
            r_par_recv_rdy <= 1'b0;
            r_state        <= OUT_DRAIN;
          end
        end
        OUT_DRAIN: begin
          if (w_send_fire) begin
            if (w_last) begin
              r_out_cnt      <= '0;
              r_send_msg     <= '0;
              r_send_val     <= 1'b0;
              r_par_recv_rdy <= 1'b1;
              r_frames_out   <= r_frames_out + 8'd1;
              r_state        <= OUT_IDLE;
            end else begin
              r_out_cnt  <= w_next_cnt;
              r_send_msg <= r_obuf[w_next_idx];
            end
          end
        end
        default: r_state <= OUT_IDLE;
      endcase
    end
  end

  assign o_par_recv_rdy = r_par_recv_rdy;
  assign o_send_msg     = r_send_msg;
  assign o_send_val     = r_send_val;
  assign o_frames_out   = r_frames_out;

endmodule

// File: rtl/fft_frame_gearbox.sv
// fft_frame_gearbox: serial<->parallel frame adapter around the FFT core.
// Collects a serial word stream into a frame of run-time length 1<<L,
// offers it in parallel to the FFT, and drains the returned result frame
// back out serially (optionally in bit-reversed order).
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   cfg_log2_len                 - requested frame length exponent (clamped to 1..LOG2N)
//   cfg_bitrev                   - 1 = drain results in bit-reversed index order
//   recv_msg/_val, recv_rdy      - serial input stream
//   par_send_msg/_val, _rdy      - assembled frame towards the FFT
//   par_recv_msg/_val, _rdy      - result frame from the FFT
//   send_msg/_val, send_rdy      - serial output stream
//   frames_in, frames_out        - wrapping frame counters for status
module fft_frame_gearbox
  import fft_frame_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned LOG2N     = $clog2(N_SAMPLES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(LOG2N+1)-1:0]     cfg_log2_len,
  input  logic                           cfg_bitrev,
  input  logic [BIT_WIDTH-1:0]           recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [N_SAMPLES*BIT_WIDTH-1:0] par_send_msg,
  output logic                           par_send_val,
  input  logic                           par_send_rdy,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0] par_recv_msg,
  input  logic                           par_recv_val,
  output logic                           par_recv_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg,
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [7:0]                     frames_in,
  output logic [7:0]                     frames_out
);

  localparam int unsigned LW = $clog2(LOG2N + 1);
  localparam int unsigned CW = LOG2N;

  in_state_e            r_in_state;
  logic [CW-1:0]        r_in_cnt;
  logic [LW-1:0]        r_len_in;
  logic [LW-1:0]        r_len_tag;
  logic [BIT_WIDTH-1:0] r_ibuf [N_SAMPLES];
  logic                 r_recv_rdy;
  logic                 r_par_send_val;
  logic [7:0]           r_frames_in;

  logic [LW-1:0]        w_l_word0;
  logic [LW-1:0]        w_l_cur;
  logic                 w_last;
  logic                 w_recv_fire;
  logic                 w_par_fire;

  // Length applies from word 0 onward; later cfg changes are not looked at.
  assign w_l_word0   = LW'(clamp_log2(32'(cfg_log2_len), LOG2N));
  assign w_l_cur     = (r_in_cnt == '0) ? w_l_word0 : r_len_in;
  assign w_last      = (32'(r_in_cnt) == ((32'd1 << w_l_cur) - 32'd1));
  assign w_recv_fire = recv_val & r_recv_rdy;
  assign w_par_fire  = r_par_send_val & par_send_rdy;

  // Input FSM. ibuf is wiped when a frame is handed over, so slots beyond
  // a shorter frame's length always read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_state     <= IN_FILL;
      r_in_cnt       <= '0;
      r_len_in       <= '0;
      r_len_tag      <= '0;
      r_recv_rdy     <= 1'b1;
      r_par_send_val <= 1'b0;
      r_frames_in    <= '0;
      for (int unsigned i = 0; i < N_SAMPLES; i++) begin
        r_ibuf[CW'(i)] <= '0;
      end
    end else begin
      case (r_in_state)
        IN_FILL: begin
          if (w_recv_fire) begin
            r_ibuf[r_in_cnt] <= recv_msg;
            if (r_in_cnt == '0) begin
              r_len_in <= w_l_word0;
            end
            if (w_last) begin
              r_in_cnt       <= '0;
              r_recv_rdy     <= 1'b0;
              r_par_send_val <= 1'b1;
              r_in_state     <= IN_HOLD;
            end else begin
              r_in_cnt <= r_in_cnt + CW'(1);
            end
          end
        end
        IN_HOLD: begin
          if (w_par_fire) begin
            r_recv_rdy     <= 1'b1;
            r_par_send_val <= 1'b0;
            r_frames_in    <= r_frames_in + 8'd1;
            r_len_tag      <= r_len_in;
            r_in_state     <= IN_FILL;
            for (int unsigned i = 0; i < N_SAMPLES; i++) begin
              r_ibuf[CW'(i)] <= '0;
            end
          end
        end
        default: r_in_state <= IN_FILL;
      endcase
    end
  end

  for (genvar g = 0; g < N_SAMPLES; g++) begin : g_par
    assign par_send_msg[g*BIT_WIDTH +: BIT_WIDTH] = r_ibuf[g];
  end

  assign recv_rdy     = r_recv_rdy;
  assign par_send_val = r_par_send_val;
  assign frames_in    = r_frames_in;

  // The FFT holds one frame at a time, so the tag always matches the
  // frame that comes back next.
  fft_frame_drain #(
    .BIT_WIDTH (BIT_WIDTH),
    .N_SAMPLES (N_SAMPLES),
    .LOG2N     (LOG2N)
  ) u_drain (
    .clk            (clk),
    .reset          (reset),
    .i_len_log2     (r_len_tag),
    .i_bitrev       (cfg_bitrev),
    .i_par_recv_msg (par_recv_msg),
    .i_par_recv_val (par_recv_val),
    .o_par_recv_rdy (par_recv_rdy),
    .o_send_msg     (send_msg),
    .o_send_val     (send_val),
    .i_send_rdy     (send_rdy),
    .o_frames_out   (frames_out)
  );

endmodule

// File: tb/tb_fft_frame_gearbox.sv
// Bench for fft_frame_gearbox: an FFT stand-in loops frames back one at a
// time; a negedge monitor holds a queue-based model of frames and words.
module tb_fft_frame_gearbox;

  localparam int BW    = 32;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int PW    = N * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    cfg_log2_len = 2'd3;
  logic          cfg_bitrev = 1'b0;
  logic [BW-1:0] recv_msg = '0;
  logic          recv_val = 1'b0;
  logic          recv_rdy;
  logic [PW-1:0] par_send_msg;
  logic          par_send_val;
  logic          par_send_rdy = 1'b0;
  logic [PW-1:0] par_recv_msg = '0;
  logic          par_recv_val = 1'b0;
  logic          par_recv_rdy;
  logic [BW-1:0] send_msg;
  logic          send_val;
  logic          send_rdy = 1'b1;
  logic [7:0]    frames_in;
  logic [7:0]    frames_out;

  fft_frame_gearbox #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_log2_len (cfg_log2_len),
    .cfg_bitrev   (cfg_bitrev),
    .recv_msg     (recv_msg),
    .recv_val     (recv_val),
    .recv_rdy     (recv_rdy),
    .par_send_msg (par_send_msg),
    .par_send_val (par_send_val),
    .par_send_rdy (par_send_rdy),
    .par_recv_msg (par_recv_msg),
    .par_recv_val (par_recv_val),
    .par_recv_rdy (par_recv_rdy),
    .send_msg     (send_msg),
    .send_val     (send_val),
    .send_rdy     (send_rdy),
    .frames_in    (frames_in),
    .frames_out   (frames_out)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_l(input int c);
    if (c < 1) return 1;
    if (c > LOG2N) return LOG2N;
    return c;
  endfunction

  // Position k of a 2^l frame reads sample rev(k): k's l-bit digits reversed.
  function automatic int rev_idx(input int k, input int l);
    int r;
    r = 0;
    for (int b = 0; b < l; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  // Reference model state (owned by the monitor).
  int            m_cnt = 0;
  int            m_len = 2;
  logic [BW-1:0] m_words [N];
  logic [PW-1:0] m_frame;
  logic [PW-1:0] exp_par_q [$];
  int            len_q [$];
  logic [BW-1:0] exp_out_q [$];
  bit            last_q [$];
  logic [BW-1:0] got_q [$];
  logic [7:0]    m_fin = '0;
  logic [7:0]    m_fout = '0;
  bit            exp_hold_next = 0;
  bit            exp_drain_next = 0;
  bit            prev_stall = 0;
  logic [BW-1:0] prev_msg = '0;
  int            mo_n, mo_l;

  // FFT stand-in state.
  bit            f_in = 0;
  bit            f_out = 0;
  bit            busy = 0;
  bit            fft_hold = 0;
  logic [PW-1:0] fft_cap = '0;
  logic [PW-1:0] fft_data = '0;
  int            bp_mode = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_cnt = 0;
      exp_par_q.delete(); len_q.delete(); exp_out_q.delete(); last_q.delete();
      m_fin = '0; m_fout = '0;
      exp_hold_next = 0; exp_drain_next = 0; prev_stall = 0;
    end else begin
      chk("frames_in", PW'(frames_in), PW'(m_fin));
      chk("frames_out", PW'(frames_out), PW'(m_fout));
      if (exp_hold_next) begin
        chk("hold_lat_val", PW'(par_send_val), PW'(1));
        chk("hold_lat_rdy", PW'(recv_rdy), PW'(0));
        exp_hold_next = 0;
      end
      if (exp_drain_next) begin
        chk("drain_lat_val", PW'(send_val), PW'(1));
        exp_drain_next = 0;
      end
      if (prev_stall) chk("stall_hold", PW'(send_msg), PW'(prev_msg));
      prev_stall = send_val && !send_rdy;
      prev_msg   = send_msg;

      if (recv_val && recv_rdy) begin
        if (m_cnt == 0) m_len = 1 << clamp_l(int'(cfg_log2_len));
        m_words[m_cnt] = recv_msg;
        m_cnt++;
        if (m_cnt == m_len) begin
          m_frame = '0;
          for (int i = 0; i < m_len; i++) m_frame[i*BW +: BW] = m_words[i];
          exp_par_q.push_back(m_frame);
          len_q.push_back(m_len);
          m_cnt = 0;
          exp_hold_next = 1;
        end
      end

      if (par_send_val && par_send_rdy) begin
        chk("no_bypass", PW'(recv_rdy), PW'(0));
        if (exp_par_q.size() == 0) chk("par_unexpected", PW'(1), PW'(0));
        else chk("par_msg", par_send_msg, exp_par_q.pop_front());
        m_fin   = m_fin + 8'd1;
        fft_cap = par_send_msg;
        f_in    = 1;
      end

      if (par_recv_val && par_recv_rdy) begin
        if (len_q.size() == 0) begin
          chk("recv_unexpected", PW'(1), PW'(0));
        end else begin
          mo_n = len_q.pop_front();
          mo_l = 0;
          while ((1 << mo_l) < mo_n) mo_l++;
          for (int k = 0; k < mo_n; k++) begin
            exp_out_q.push_back(par_recv_msg[(cfg_bitrev ? rev_idx(k, mo_l) : k)*BW +: BW]);
            last_q.push_back(k == mo_n - 1);
          end
        end
        exp_drain_next = 1;
        f_out = 1;
      end

      if (send_val && send_rdy) begin
        got_q.push_back(send_msg);
        if (exp_out_q.size() == 0) begin
          chk("send_unexpected", PW'(1), PW'(0));
        end else begin
          chk("send_msg", PW'(send_msg), PW'(exp_out_q.pop_front()));
          if (last_q.pop_front()) m_fout = m_fout + 8'd1;
        end
      end
    end
  end

  // FFT stand-in: accepts one frame, returns it unchanged the next cycle.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      busy = 0;
    end else begin
      if (f_out) busy = 0;
      if (f_in) begin
        busy = 1;
        fft_data = fft_cap;
      end
    end
    f_in = 0;
    f_out = 0;
    par_recv_val = busy;
    par_recv_msg = busy ? fft_data : '0;
    par_send_rdy = !busy && !fft_hold;
  end

  // Output backpressure: 0 always ready, 1 toggling, 2 random.
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       send_rdy = 1'b1;
      1:       send_rdy = !send_rdy;
      default: send_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_word(input logic [BW-1:0] w);
    bit got;
    int n;
    got = 0; n = 0;
    recv_msg = w;
    recv_val = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk); got = recv_rdy;
      @(posedge clk); #1; n++;
    end
    recv_val = 1'b0;
    if (!got) chk("recv_timeout", PW'(0), PW'(1));
  endtask

  task automatic wait_quiet();
    bit q;
    int n;
    q = 0; n = 0;
    while (!q && n < 3000) begin
      @(negedge clk);
      q = exp_par_q.size() == 0 && len_q.size() == 0 && exp_out_q.size() == 0 &&
          !busy && !par_send_val && !send_val && m_cnt == 0;
      @(posedge clk); #1; n++;
    end
    if (!q) chk("quiet_timeout", PW'(0), PW'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    recv_val = 1'b0;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_par_val", PW'(par_send_val), PW'(0));
    chk("rst_par_msg", par_send_msg, PW'(0));
    chk("rst_send_val", PW'(send_val), PW'(0));
    chk("rst_send_msg", PW'(send_msg), PW'(0));
    chk("rst_fin", PW'(frames_in), PW'(0));
    chk("rst_fout", PW'(frames_out), PW'(0));
    chk("rst_recv_rdy", PW'(recv_rdy), PW'(1));
    chk("rst_precv_rdy", PW'(par_recv_rdy), PW'(1));
    @(posedge clk); #1;
  endtask

  task automatic chk_got(input string tag, input int base, input int cnt);
    chk({tag, "_n"}, PW'(got_q.size()), PW'(cnt));
    for (int i = 0; i < cnt && i < got_q.size(); i++) chk(tag, PW'(got_q[i]), PW'(base + i));
  endtask

  int tbl [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int n, fin0;
  bit seen;

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Natural order, full length.
    cfg_log2_len = 2'd3; cfg_bitrev = 1'b0; bp_mode = 0; got_q.delete();
    for (int i = 1; i <= 8; i++) push_word(BW'(i));
    wait_quiet();
    chk_got("plain", 1, 8);
    chk("plain_fin", PW'(frames_in), PW'(1));
    chk("plain_fout", PW'(frames_out), PW'(1));

    // Bit-reversed drain.
    cfg_bitrev = 1'b1; got_q.delete();
    for (int i = 0; i < 8; i++) push_word(BW'(i));
    wait_quiet();
    chk("brev_n", PW'(got_q.size()), PW'(8));
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("brev", PW'(got_q[i]), PW'(tbl[i]));

    // Length 4 with a cfg change after word 1.
    cfg_bitrev = 1'b0; cfg_log2_len = 2'd2; got_q.delete();
    push_word(BW'(10)); push_word(BW'(11));
    cfg_log2_len = 2'd3;
    push_word(BW'(12)); push_word(BW'(13));
    wait_quiet();
    chk_got("len4", 10, 4);
    chk("len4_fin", PW'(frames_in), PW'(3));

    // Overlap: A drains with toggling send_rdy while B fills and is held.
    bp_mode = 1; got_q.delete(); fin0 = int'(frames_in);
    for (int i = 0; i < 8; i++) push_word(BW'(100 + i));
    n = 0; seen = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = (int'(frames_in) != fin0);
      @(posedge clk); #1; n++;
    end
    chk("ovl_a_taken", PW'(seen), PW'(1));
    fft_hold = 1;
    for (int i = 0; i < 8; i++) push_word(BW'(200 + i));
    n = 0; seen = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = par_send_val;
      @(posedge clk); #1; n++;
    end
    chk("ovl_b_hold", PW'(seen), PW'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_recv_rdy", PW'(recv_rdy), PW'(0));
      chk("hold_par_val", PW'(par_send_val), PW'(1));
      @(posedge clk); #1;
    end
    fft_hold = 0;
    wait_quiet();
    chk("ovl_n", PW'(got_q.size()), PW'(16));
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("ovl_a", PW'(got_q[i]), PW'(100 + i));
    for (int i = 8; i < 16 && i < got_q.size(); i++) chk("ovl_b", PW'(got_q[i]), PW'(192 + i));

    // Random stream: length, order, gaps and backpressure all vary.
    bp_mode = 2;
    for (int i = 0; i < 160; i++) begin
      cfg_log2_len = 2'($urandom_range(0, 3));
      cfg_bitrev   = 1'($urandom_range(0, 1));
      idle(int'($urandom_range(0, 2)));
      push_word($urandom);
    end
    n = 0;
    while (m_cnt != 0 && n < 20) begin push_word($urandom); n++; end
    wait_quiet();

    // Reset mid-fill, then mid-drain, then a clean frame.
    bp_mode = 0; cfg_log2_len = 2'd3; cfg_bitrev = 1'b0;
    for (int i = 0; i < 3; i++) push_word(BW'(70 + i));
    do_reset();
    bp_mode = 1;
    for (int i = 0; i < 8; i++) push_word(BW'(80 + i));
    n = 0; seen = 0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = send_val;
      @(posedge clk); #1; n++;
    end
    chk("rst_drain_seen", PW'(seen), PW'(1));
    do_reset();
    bp_mode = 0; got_q.delete();
    for (int i = 0; i < 8; i++) push_word(BW'(50 + i));
    wait_quiet();
    chk_got("post_rst", 50, 8);
    chk("post_rst_fin", PW'(frames_in), PW'(1));

    // Clamp to 2-word frames and wrap the counters.
    do_reset();
    cfg_log2_len = 2'd0; got_q.delete();
    for (int f = 0; f < 255; f++) begin
      cfg_bitrev = 1'($urandom_range(0, 1));
      push_word($urandom); push_word($urandom);
    end
    wait_quiet();
    chk("clamp_words", PW'(got_q.size()), PW'(510));
    chk("wrap_fin_255", PW'(frames_in), PW'(255));
    push_word($urandom); push_word($urandom);
    wait_quiet();
    chk("wrap_fin_0", PW'(frames_in), PW'(0));
    chk("wrap_fout_0", PW'(frames_out), PW'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_gearbox.md
Name: fft_frame_gearbox

Overview:
- Parametrised successor to the separate deserializer/serializer pair that sits between the SPI minion adapters and the FFT core.
- Input side: collects a serial val/rdy word stream into a frame and presents it in parallel to the FFT.
- Output side: accepts the parallel FFT result and drains it back as a serial stream.
- Adds behaviour the current pair lacks: run-time frame length, optional bit-reversed drain order, and frame counters for status readback.

Parameters:
- BIT_WIDTH, 32, width of one sample word.
- N_SAMPLES, 8, maximum frame length; must be a power of two, at least 2.
- LOG2N, $clog2(N_SAMPLES), derived; not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_log2_len  in  $clog2(LOG2N+1)  requested frame length exponent; active length = 1<<L
- cfg_bitrev  in  1  1 = drain output in bit-reversed index order
- recv_msg  in  BIT_WIDTH  serial input word
- recv_val  in  1  input valid
- recv_rdy  out  1  input ready
- par_send_msg  out  N_SAMPLES x BIT_WIDTH  assembled frame to FFT
- par_send_val  out  1  frame valid
- par_send_rdy  in  1  FFT ready
- par_recv_msg  in  N_SAMPLES x BIT_WIDTH  FFT result frame
- par_recv_val  in  1  result valid
- par_recv_rdy  out  1  gearbox ready for result
- send_msg  out  BIT_WIDTH  serial output word
- send_val  out  1  output valid
- send_rdy  in  1  output ready
- frames_in  out  8  count of frames handed to the FFT, wraps at 255
- frames_out  out  8  count of frames fully drained, wraps at 255

Behaviour:
- Reset: both FSMs go to their first state; counters, buffers and all outputs are 0, except recv_rdy=1 and par_recv_rdy=1 from the first cycle after reset.
- Reset mid-frame discards partial input and undrained output; no partial frame is emitted.
- Length: L = clamp(cfg_log2_len, 1, LOG2N); len = 1<<L.
- L is sampled on acceptance of word 0 of a frame into len_in_q. cfg changes mid-frame are ignored.
- cfg_bitrev is sampled into bitrev_q on the par_recv fire.
- Input FSM, FILL: recv_rdy=1. Each recv fire writes ibuf[in_cnt] and increments in_cnt. The fire with in_cnt==len_in_q-1 moves to HOLD.
- Input FSM, HOLD: recv_rdy=0; par_send_val=1.
  - par_send_msg = ibuf, with slots >= len_in_q forced to 0.
  - On par_send fire: go to FILL, in_cnt=0, frames_in++, len_tag_q=len_in_q.
  - No same-cycle bypass: recv_rdy stays 0 during the fire cycle.
- Input latency: last word accepted in cycle t gives par_send_val=1 in cycle t+1.
- Output FSM, IDLE: par_recv_rdy=1. On par_recv fire, latch the whole result into obuf, take len_out_q=len_tag_q, set out_cnt=0, go to DRAIN.
- Output FSM, DRAIN: par_recv_rdy=0; send_val=1.
  - send_msg = obuf[idx], where idx = bitrev_q ? reverse of the low len_out_q bits of out_cnt : out_cnt.
  - Each send fire increments out_cnt.
  - The fire with out_cnt==len-1 goes to IDLE and increments frames_out.
- Output latency: par_recv fire in cycle t gives the first send_val in cycle t+1. Steady-state throughput is 1 word/cycle with send_rdy held high.
- Input and output FSMs are independent, so input of frame k+1 overlaps draining of frame k.
- The FFT holds at most one frame at a time. len_tag_q therefore always belongs to the frame returned next.
- Backpressure:
  - send_rdy=0 holds send_msg and out_cnt stable.
  - recv_val=0 in FILL holds in_cnt.
  - par_send_rdy=0 holds HOLD indefinitely with recv_rdy=0.
- Counters wrap 255 -> 0 with no flag.
- Counter updates occur on the handshake edge: visible in cycle t+1 for a fire in cycle t.

Decomposition:
- Package fft_frame_pkg holds:
  - the FSM enums (IN_FILL/IN_HOLD, OUT_IDLE/OUT_DRAIN);
  - the clamp function for L;
  - a bitrev(idx, L) function defined for L up to LOG2N.
- Sub-module fft_frame_drain implements the output FSM, obuf and bit-reversed indexing.
- The top level contains the input FSM, ibuf, tag register and counters.

Test Plan:
- N=8, L=3, bitrev=0: feed 1..8, loopback par_send->par_recv -> par_send_msg={1..8}; serial out 1,2,...,8; frames_in=frames_out=1.
- L=3, bitrev=1, loopback: input 0..7 -> output order 0,4,2,6,1,5,3,7.
- L=2 (len 4): input 10,11,12,13 -> par_send slots 4..7 are 0; output 10,11,12,13. Change cfg_log2_len to 3 after word 1 -> frame length is still 4.
- Overlap and backpressure: frame A draining with send_rdy toggling 1010... while frame B fills -> A output exact and in order; B reaches HOLD; par_send_rdy=0 keeps recv_rdy=0 for 5 cycles.
- Clamp and wrap: cfg_log2_len=0 gives a 2-word frame. Run 256 frames -> frames_in returns to 0.
- Reset after 3 of 8 words plus reset during a drain -> all outputs 0. Next full frame is produced correctly with no stale words.
